// File: rtl/format_encoder.sv
// format_encoder: three-stage posit encoder.
// Packs sign, signed regime k, exponent and hidden-bit mantissa into a
// WIDTH-bit posit with round-to-nearest-even. Valid/ready on both sides with
// a single global advance; NaR and zero flags ride the pipeline unrounded.
module format_encoder #(
    parameter int WIDTH = 7,
    parameter int EN    = 1,
    parameter int W_REG = $clog2(WIDTH) + 1,
    parameter int W_EXP = $clog2(WIDTH) + 1,
    parameter int W_MAN = WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [W_REG-1:0] in_regime,
    input  logic [W_EXP-1:0]        in_exponent,
    input  logic [W_MAN-1:0]        in_mantissa,
    input  logic                    in_zero,
    input  logic                    in_nar,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_posit
);

    // Body = posit magnitude without the sign bit.
    localparam int BW   = WIDTH - 1;
    // Tail = exponent field followed by the fraction (hidden bit dropped).
    localparam int TL   = EN + W_MAN - 1;
    // Work vector: tail plus enough room ahead of it for the longest regime.
    localparam int LEN  = TL + WIDTH;
    localparam int RL_W = $clog2(WIDTH + 1) + 1;

    // Hidden mantissa bit and exponent bits above EN carry no information.
    logic unused_bits;
    assign unused_bits = ^{in_mantissa[W_MAN-1], in_exponent[W_EXP-1:EN]};

    // Forces the body to the largest / smallest nonzero magnitude when the
    // regime alone is out of range; guard and sticky are cleared so rounding
    // leaves the saturated value untouched.
    function automatic logic [BW+1:0] saturate(input logic sat_max,
                                               input logic sat_min,
                                               input logic [BW+1:0] raw);
        if (sat_max) return {{BW{1'b1}}, 2'b00};
        if (sat_min) return {{(BW-1){1'b0}}, 1'b1, 2'b00};
        return raw;
    endfunction

    // Round-to-nearest-even on the body, clamp into [minpos, maxpos] so a
    // finite input never becomes zero or NaR, then apply the sign.
    function automatic logic [WIDTH-1:0] round_pack(input logic neg,
                                                    input logic [BW-1:0] body,
                                                    input logic guard,
                                                    input logic sticky);
        logic [BW:0]      sum;
        logic [BW-1:0]    mag;
        logic [WIDTH-1:0] word;
        sum = {1'b0, body} + {{BW{1'b0}}, guard & (sticky | body[0])};
        if (sum[BW])
            mag = {BW{1'b1}};
        else if (sum[BW-1:0] == '0)
            mag = {{(BW-1){1'b0}}, 1'b1};
        else
            mag = sum[BW-1:0];
        word = {1'b0, mag};
        if (neg)
            word = ~word + {{(WIDTH-1){1'b0}}, 1'b1};
        return word;
    endfunction

    logic adv;

    logic vld_p1_q, vld_p2_q, vld_p3_q;

    logic             sign_p1_q, zero_p1_q, nar_p1_q;
    logic             sat_max_p1_q, sat_min_p1_q, neg_k_p1_q;
    logic [RL_W-1:0]  rl_p1_q;
    logic [TL-1:0]    tail_p1_q;

    logic             sign_p2_q, zero_p2_q, nar_p2_q;
    logic [BW-1:0]    body_p2_q;
    logic             guard_p2_q, sticky_p2_q;

    logic [WIDTH-1:0] posit_p3_q;

    int               k_int;
    logic             sat_max_d, sat_min_d, neg_k_d;
    logic [RL_W-1:0]  rl_d;
    logic [TL-1:0]    tail_d;

    logic [LEN-1:0]   v;
    logic [BW-1:0]    body_d;
    logic             guard_d, sticky_d;

    logic [WIDTH-1:0] posit_d;

    // Whole pipeline moves together whenever the output slot is free.
    assign adv       = ~vld_p3_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p3_q;
    assign out_posit = posit_p3_q;

    // ---- stage 0 -> 1: saturation detect and regime run length ----
    // Classify k and compute the regime run length including its terminator.
    always_comb begin
        k_int     = int'(in_regime);
        sat_max_d = (k_int >= WIDTH - 2);
        sat_min_d = (k_int <= -(WIDTH - 1));
        neg_k_d   = (k_int < 0);
        if (sat_max_d || sat_min_d)
            rl_d = RL_W'(2);
        else if (neg_k_d)
            rl_d = RL_W'(1 - k_int);
        else
            rl_d = RL_W'(k_int + 2);
        tail_d = {in_exponent[EN-1:0], in_mantissa[W_MAN-2:0]};
    end

    // ---- stage 1 -> 2: assemble regime + tail, split body/guard/sticky ----
    // Tail is shifted behind the regime run; the regime pattern is OR-ed on top.
    always_comb begin
        v = {tail_p1_q, {WIDTH{1'b0}}} >> rl_p1_q;
        if (neg_k_p1_q)
            v = v | ({1'b1, {(LEN-1){1'b0}}} >> (rl_p1_q - RL_W'(1)));
        else
            v = v | ~({LEN{1'b1}} >> (rl_p1_q - RL_W'(1)));
        {body_d, guard_d, sticky_d} = saturate(sat_max_p1_q, sat_min_p1_q,
                                               {v[LEN-1 -: BW], v[LEN-1-BW], |v[LEN-2-BW:0]});
    end

    // ---- stage 2 -> 3: rounding, sign and special-value override ----
    // NaR wins over zero, both win over the rounded field value.
    always_comb begin
        if (nar_p2_q)
            posit_d = {1'b1, {BW{1'b0}}};
        else if (zero_p2_q)
            posit_d = '0;
        else
            posit_d = round_pack(sign_p2_q, body_p2_q, guard_p2_q, sticky_p2_q);
    end

    // Stage valids and the output word; reset flushes every in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            vld_p3_q   <= 1'b0;
            posit_p3_q <= '0;
        end else if (adv) begin
            vld_p1_q   <= in_valid;
            vld_p2_q   <= vld_p1_q;
            vld_p3_q   <= vld_p2_q;
            posit_p3_q <= posit_d;
        end
    end

    // Datapath registers for stages 1 and 2; qualified by the valids above.
    always_ff @(posedge clk) begin
        if (adv) begin
            sign_p1_q    <= in_sign;
            zero_p1_q    <= in_zero;
            nar_p1_q     <= in_nar;
            sat_max_p1_q <= sat_max_d;
            sat_min_p1_q <= sat_min_d;
            neg_k_p1_q   <= neg_k_d;
            rl_p1_q      <= rl_d;
            tail_p1_q    <= tail_d;

            sign_p2_q    <= sign_p1_q;
            zero_p2_q    <= zero_p1_q;
            nar_p2_q     <= nar_p1_q;
            body_p2_q    <= body_d;
            guard_p2_q   <= guard_d;
            sticky_p2_q  <= sticky_d;
        end
    end

endmodule
